// File: rtl/pdp8_panel_pkg.sv
// rtl/pdp8_panel_pkg.sv - shared run-state encoding and debounce defaults for the PDP-8 panel run controller.
package pdp8_panel_pkg;

    localparam int unsigned DEB_CYCLES_DEFAULT = 16;
    localparam int unsigned DEB_CNT_W          = 8;

    localparam logic [2:0] HALTED   = 3'd0;
    localparam logic [2:0] STARTING = 3'd1;
    localparam logic [2:0] RUNNING  = 3'd2;
    localparam logic [2:0] STOPPING = 3'd3;
    localparam logic [2:0] HALTING  = 3'd4;

    typedef enum logic [2:0] {
        S_HALTED   = HALTED,
        S_STARTING = STARTING,
        S_RUNNING  = RUNNING,
        S_STOPPING = STOPPING,
        S_HALTING  = HALTING
    } run_state_e;

    // The sequencer keeps stepping in every state between the clear pulse and the park pulse.
    function automatic logic seq_run_of(input run_state_e s);
        return (s == S_STARTING) || (s == S_RUNNING) || (s == S_STOPPING);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 2-flop synchronizer plus agreement-reset counter debouncer for one console switch.
module switch_debounce
    import pdp8_panel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sw_i,
    output logic level_o
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);
    localparam logic [DEB_CNT_W-1:0] CNT_ONE  = DEB_CNT_W'(1);

    logic [1:0]           sync_q;
    logic                 level_q;
    logic [DEB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], sw_i};
            // Only an unbroken run of disagreeing samples may flip the level.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/panel_run_ctl.sv
// rtl/panel_run_ctl.sv - PDP-8 front-panel run controller: switch events, run FSM, sequencer/lamp outputs.
// SINGLE_INST_EN enables the SING INST switch; without it the machine always free-runs.
module panel_run_ctl
    import pdp8_panel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SW_START,
    input  logic SW_CONT,
    input  logic SW_STOP,
    input  logic SW_SINGLE,
    input  logic INST_DONE,
    input  logic HLT_REQ,
    output logic SEQ_RUN,
    output logic SEQ_RESET,
    output logic CLR_PULSE,
    output logic RUN_LAMP
);

    logic start_deb;
    logic cont_deb;
    logic stop_deb;
    logic mode;

    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk_i   (CLK),
        .reset_i (RESET),
        .sw_i    (SW_START),
        .level_o (start_deb)
    );

    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cont (
        .clk_i   (CLK),
        .reset_i (RESET),
        .sw_i    (SW_CONT),
        .level_o (cont_deb)
    );

    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk_i   (CLK),
        .reset_i (RESET),
        .sw_i    (SW_STOP),
        .level_o (stop_deb)
    );

`ifdef SINGLE_INST_EN
    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_single (
        .clk_i   (CLK),
        .reset_i (RESET),
        .sw_i    (SW_SINGLE),
        .level_o (mode)
    );
`else
    logic unused_single;
    assign unused_single = SW_SINGLE;
    assign mode          = 1'b0;
`endif

    // Bit order {stop, cont, start}; a press is a registered rising edge of the debounced level.
    logic [2:0] deb_now;
    logic [2:0] deb_prev_q;
    logic [2:0] press_q;

    assign deb_now = {stop_deb, cont_deb, start_deb};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            deb_prev_q <= '0;
            press_q    <= '0;
        end else begin
            deb_prev_q <= deb_now;
            press_q    <= deb_now & ~deb_prev_q;
        end
    end

    logic start_press;
    logic cont_press;
    logic stop_press;

    assign start_press = press_q[0];
    assign cont_press  = press_q[1];
    assign stop_press  = press_q[2];

    run_state_e state_q;
    run_state_e state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALTED: begin
                if (start_press) begin
                    state_d = S_STARTING;
                end else if (cont_press) begin
                    state_d = mode ? S_STOPPING : S_RUNNING;
                end
            end
            S_STARTING: state_d = mode ? S_STOPPING : S_RUNNING;
            S_RUNNING: begin
                // Stopping on the boundary itself skips STOPPING so no extra instruction starts.
                if (INST_DONE && (HLT_REQ || stop_press)) begin
                    state_d = S_HALTING;
                end else if (stop_press || mode) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (INST_DONE) begin
                    state_d = S_HALTING;
                end
            end
            S_HALTING: state_d = S_HALTED;
            default:   state_d = S_HALTED;
        endcase
    end

    logic run_q;
    logic seq_reset_q;
    logic clr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_HALTED;
            run_q       <= 1'b0;
            seq_reset_q <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= seq_run_of(state_d);
            seq_reset_q <= (state_d == S_HALTING);
            clr_q       <= (state_d == S_STARTING);
        end
    end

    assign SEQ_RUN   = run_q;
    assign RUN_LAMP  = run_q;
    assign SEQ_RESET = seq_reset_q;
    assign CLR_PULSE = clr_q;

endmodule

// File: tb/tb_panel_run_ctl.sv
// tb/tb_panel_run_ctl.sv - self-checking bench for panel_run_ctl: directed scenarios plus randomized switch traffic.
module tb_panel_run_ctl;

    localparam int DEB = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic SW_START;
    logic SW_CONT;
    logic SW_STOP;
    logic SW_SINGLE;
    logic INST_DONE;
    logic HLT_REQ;
    logic SEQ_RUN;
    logic SEQ_RESET;
    logic CLR_PULSE;
    logic RUN_LAMP;

    int n_tests = 0;
    int n_fail  = 0;
    int rst_pulses = 0;

    panel_run_ctl #(.DEB_CYCLES(DEB)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SW_START  (SW_START),
        .SW_CONT   (SW_CONT),
        .SW_STOP   (SW_STOP),
        .SW_SINGLE (SW_SINGLE),
        .INST_DONE (INST_DONE),
        .HLT_REQ   (HLT_REQ),
        .SEQ_RUN   (SEQ_RUN),
        .SEQ_RESET (SEQ_RESET),
        .CLR_PULSE (CLR_PULSE),
        .RUN_LAMP  (RUN_LAMP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 halted, 1 starting, 2 running, 3 stopping, 4 halting.
    // A switch level flips once the last DEB synchronized samples all disagree with it;
    // the synchronized sample lags the raw sample by two edges, and a press reaches the
    // run logic two edges after the debounced level rises.
    int        m_state;
    bit [15:0] m_hist [4];
    bit        m_deb  [4];
    bit        m_rose [4];
    bit        m_press[4];

    task automatic model_edge();
        bit [3:0] raw;
        bit       mode;
        bit       differ;
        int       nxt;
        raw = {SW_SINGLE, SW_STOP, SW_CONT, SW_START};
        if (RESET) begin
            m_state = 0;
            for (int i = 0; i < 4; i++) begin
                m_hist[i]  = '0;
                m_deb[i]   = 1'b0;
                m_rose[i]  = 1'b0;
                m_press[i] = 1'b0;
            end
            return;
        end
`ifdef SINGLE_INST_EN
        mode = m_deb[3];
`else
        mode = 1'b0;
`endif
        nxt = m_state;
        case (m_state)
            0: begin
                if (m_press[0])      nxt = 1;
                else if (m_press[1]) nxt = mode ? 3 : 2;
            end
            1: nxt = mode ? 3 : 2;
            2: begin
                if (INST_DONE && (HLT_REQ || m_press[2])) nxt = 4;
                else if (m_press[2] || mode)             nxt = 3;
            end
            3: if (INST_DONE) nxt = 4;
            default: nxt = 0;
        endcase
        m_state = nxt;
        for (int i = 0; i < 4; i++) begin
            m_press[i] = m_rose[i];
            differ = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (m_hist[i][k] == m_deb[i]) differ = 1'b0;
            end
            m_rose[i] = differ && !m_deb[i];
            if (differ) m_deb[i] = !m_deb[i];
            m_hist[i] = {m_hist[i][14:0], raw[i]};
        end
    endtask

    task automatic tick();
        bit e_run;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        e_run = (m_state >= 1) && (m_state <= 3);
        check("seq_run",   SEQ_RUN,   e_run);
        check("run_lamp",  RUN_LAMP,  e_run);
        check("seq_reset", SEQ_RESET, m_state == 4);
        check("clr_pulse", CLR_PULSE, m_state == 1);
        if (SEQ_RESET === 1'b1) rst_pulses++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_sw(input int idx, input logic v);
        case (idx)
            0:       SW_START  = v;
            1:       SW_CONT   = v;
            2:       SW_STOP   = v;
            default: SW_SINGLE = v;
        endcase
    endtask

    task automatic press_sw(input int idx, input int hold);
        set_sw(idx, 1'b1);
        repeat (hold) tick();
        set_sw(idx, 1'b0);
    endtask

    task automatic pulse_done(input logic hlt);
        INST_DONE = 1'b1;
        HLT_REQ   = hlt;
        tick();
        INST_DONE = 1'b0;
        HLT_REQ   = 1'b0;
    endtask

    task automatic start_machine();
        press_sw(0, 10);
        idle(8);
    endtask

    task automatic wait_clr(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (CLR_PULSE === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        RESET = 1'b1;
        SW_START = 1'b1; SW_CONT = 1'b1; SW_STOP = 1'b1; SW_SINGLE = 1'b1;
        INST_DONE = 1'b0; HLT_REQ = 1'b0;

        // Reset with every switch held: nothing may happen in the first cycles after release.
        idle(3);
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_hold_run", SEQ_RUN, 1'b0);
            check("rst_hold_clr", CLR_PULSE, 1'b0);
        end
        SW_START = 1'b0; SW_CONT = 1'b0; SW_STOP = 1'b0; SW_SINGLE = 1'b0;
        RESET = 1'b1;
        idle(3);
        RESET = 1'b0;
        idle(4);

        // START latency, single clear pulse, then HLT.
        SW_START = 1'b1;
        wait_clr(lat);
        check("start_lat", lat, 7);
        check("start_run", SEQ_RUN, 1'b1);
        check("start_lamp", RUN_LAMP, 1'b1);
        tick();
        check("clr_once", CLR_PULSE, 1'b0);
        tick();
        SW_START = 1'b0;
        idle(8);
        pulse_done(1'b1);
        check("hlt_rst", SEQ_RESET, 1'b1);
        check("hlt_run", SEQ_RUN, 1'b0);
        tick();
        check("hlt_rst_end", SEQ_RESET, 1'b0);
        idle(3);

        // STOP waits for the instruction boundary.
        start_machine();
        press_sw(2, 8);
        idle(8);
        check("stop_run", SEQ_RUN, 1'b1);
        pulse_done(1'b0);
        check("stop_rst", SEQ_RESET, 1'b1);
        tick();
        check("stop_halted", SEQ_RUN, 1'b0);
        idle(3);

        // Bounce on STOP and CONT while running are both ignored.
        start_machine();
        for (int k = 0; k < 4; k++) begin
            SW_STOP = (k % 2 == 0);
            tick();
        end
        SW_STOP = 1'b0;
        idle(10);
        check("bounce_run", SEQ_RUN, 1'b1);
        press_sw(1, 8);
        idle(6);
        check("cont_ign_run", SEQ_RUN, 1'b1);
        pulse_done(1'b1);
        idle(4);

        // START and CONT in the same cycle: START wins.
        SW_START = 1'b1;
        SW_CONT  = 1'b1;
        wait_clr(lat);
        check("sc_lat", lat, 7);
        tick();
        SW_START = 1'b0;
        SW_CONT  = 1'b0;
        idle(8);
        check("sc_run", SEQ_RUN, 1'b1);
        pulse_done(1'b1);
        idle(4);

        // STOP press landing on INST_DONE goes straight to HALTING.
        start_machine();
        SW_STOP = 1'b1;
        idle(7);
        pulse_done(1'b0);
        check("stopdone_rst", SEQ_RESET, 1'b1);
        SW_STOP = 1'b0;
        tick();
        check("stopdone_run", SEQ_RUN, 1'b0);
        idle(8);

        // RESET in STOPPING halts without a park pulse.
        start_machine();
        press_sw(2, 8);
        idle(4);
        check("rst_stop_pre", SEQ_RUN, 1'b1);
        RESET = 1'b1;
        tick();
        check("rst_stop_rst", SEQ_RESET, 1'b0);
        check("rst_stop_run", SEQ_RUN, 1'b0);
        RESET = 1'b0;
        tick();
        check("rst_stop_rst2", SEQ_RESET, 1'b0);
        idle(4);

`ifdef SINGLE_INST_EN
        // Single instruction: each CONT runs exactly one instruction.
        SW_SINGLE = 1'b1;
        idle(10);
        rst_pulses = 0;
        for (int r = 0; r < 3; r++) begin
            press_sw(1, 8);
            idle(4);
            check("si_stopping", SEQ_RUN, 1'b1);
            pulse_done(1'b0);
            idle(2);
            check("si_halted", SEQ_RUN, 1'b0);
        end
        check("si_pulses", rst_pulses, 3);
        SW_SINGLE = 1'b0;
        idle(10);
`endif

        // Randomized switch traffic, instruction boundaries and occasional resets.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 11) == 0) SW_START  = ~SW_START;
            if ($urandom_range(0, 9)  == 0) SW_CONT   = ~SW_CONT;
            if ($urandom_range(0, 7)  == 0) SW_STOP   = ~SW_STOP;
            if ($urandom_range(0, 39) == 0) SW_SINGLE = ~SW_SINGLE;
            INST_DONE = ($urandom_range(0, 3) == 0);
            HLT_REQ   = ($urandom_range(0, 7) == 0);
            RESET     = ($urandom_range(0, 499) == 0);
            tick();
        end
        RESET = 1'b0;
        INST_DONE = 1'b0;
        HLT_REQ = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
